// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_pkg
//  Purpose  : Shared types and helpers for the key-matrix scanner.
//             - key_evt_t    : one press/release event as stored in the FIFO
//             - scan_state_e : scanner FSM state encoding
//             - idx_width()  : index width for n items (minimum 1 bit)
//  Revision : 1.0  initial release
// ============================================================================
package keypad_pkg;

   // Event records carry an index wide enough for matrices up to 256 keys.
   // The scanner narrows it to the index width its own geometry needs.
   localparam int KEY_IDX_W = 8;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef struct packed {
      logic [KEY_IDX_W-1:0] index;
      logic                 pressed;
   } key_evt_t;

   typedef enum logic [1:0] {
      DRIVE  = 2'd0,
      SAMPLE = 2'd1,
      EMIT   = 2'd2
   } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/keypad_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_event_fifo
//  Purpose  : Synchronous show-ahead FIFO of key_evt_t. Head entry is visible
//             on 'head' whenever 'empty' is low; writes are registered, so a
//             pushed entry becomes visible the cycle after the push.
//  Ports    : clk, rst        clock, async active-high reset
//             push, push_data write request and data (ignored when full)
//             pop             read request (ignored when empty)
//             head            entry at the read pointer
//             empty, full     status from the registered occupancy count
//             count           occupancy, 0..DEPTH
//  Revision : 1.0  initial release
// ============================================================================
module keypad_event_fifo
   import keypad_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  key_evt_t                 push_data,
   input  logic                     pop,
   output key_evt_t                 head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = idx_width(DEPTH);

   key_evt_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Full/empty come from the registered count, so a push into a full FIFO
   // is refused even when a pop happens in the same cycle.
   assign empty   = (count == '0);
   assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : ROWS x COLS key-matrix scanner. Drives one row low at a time,
//             synchronises the columns, debounces every key independently and
//             reports press/release events through a ready/valid FIFO.
//  Ports    : clk, rst      clock, async active-high reset
//             col_inputs    column pins, active-low, asynchronous
//             row_outputs   row drive, one-hot active-low
//             evt_valid     event available at FIFO head
//             evt_ready     consumer accepts event
//             evt_index     key index = row*COLS + col
//             evt_pressed   1 = press, 0 = release
//             key_state     debounced state bitmap, 1 = held
//             any_pressed   OR of key_state
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SETTLE_CYCLES  = 4,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int FIFO_DEPTH     = 4
)(
   input  logic                                clk,
   input  logic                                rst,
   input  logic [COLS-1:0]                     col_inputs,
   output logic [ROWS-1:0]                     row_outputs,
   output logic                                evt_valid,
   input  logic                                evt_ready,
   output logic [idx_width(ROWS*COLS)-1:0]     evt_index,
   output logic                                evt_pressed,
   output logic [ROWS*COLS-1:0]                key_state,
   output logic                                any_pressed
);

   localparam int KEYS  = ROWS * COLS;
   localparam int IDX_W = idx_width(KEYS);
   localparam int ROW_W = idx_width(ROWS);
   localparam int COL_W = idx_width(COLS);
   localparam int SET_W = idx_width(SETTLE_CYCLES);
   localparam int CNT_W = idx_width(DEBOUNCE_SCANS + 1);

   // ---------------------------------------------------------------- state
   scan_state_e      state, state_nx;
   logic [ROW_W-1:0] row,    row_nx;
   logic [COL_W-1:0] col,    col_nx;
   logic [SET_W-1:0] settle, settle_nx;

   logic [COLS-1:0]  sync1;
   logic [COLS-1:0]  sync2;
   logic [COLS-1:0]  raw;
   logic [CNT_W-1:0] cnt [KEYS];

   // ---------------------------------------------------------------- datapath
   logic [IDX_W-1:0] key_idx;
   logic             sample_bit;
   logic [CNT_W-1:0] cur_cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             cnt_we;
   logic             push;

   key_evt_t                  push_data;
   key_evt_t                  fifo_head;
   logic                      fifo_empty;
   logic                      fifo_full;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                      unused_fifo;

   assign key_idx    = IDX_W'(int'(row) * COLS + int'(col));
   assign sample_bit = raw[col];
   assign cur_cnt    = cnt[key_idx];
   assign push_data  = '{index: KEY_IDX_W'(key_idx), pressed: sample_bit};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= DRIVE;
         row    <= '0;
         col    <= '0;
         settle <= '0;
      end else begin
         state  <= state_nx;
         row    <= row_nx;
         col    <= col_nx;
         settle <= settle_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      row_nx    = row;
      col_nx    = col;
      settle_nx = settle;
      cnt_we    = 1'b0;
      cnt_nx    = '0;
      push      = 1'b0;
      case (state)
         DRIVE: begin
            if (settle == SET_W'(SETTLE_CYCLES - 1)) begin
               settle_nx = '0;
               state_nx  = SAMPLE;
            end else begin
               settle_nx = settle + 1'b1;
            end
         end
         SAMPLE: begin
            state_nx = EMIT;
            col_nx   = '0;
         end
         EMIT: begin
            cnt_we = 1'b1;
            if (sample_bit == key_state[key_idx]) begin
               cnt_nx = '0;
            end else if (int'(cur_cnt) + 1 < DEBOUNCE_SCANS) begin
               cnt_nx = cur_cnt + 1'b1;
            end else if (!fifo_full) begin
               push   = 1'b1;
               cnt_nx = '0;
            end else begin
               // No room: hold the counter at its threshold so the key flips
               // (and reports) on the next visit that finds space.
               cnt_nx = CNT_W'(DEBOUNCE_SCANS - 1);
            end
            if (col == COL_W'(COLS - 1)) begin
               col_nx   = '0;
               state_nx = DRIVE;
               row_nx   = (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
            end else begin
               col_nx = col + 1'b1;
            end
         end
         default: begin
            state_nx = DRIVE;
         end
      endcase
   end

   // ---------------------------------------------------------------- registers
   // row_outputs is registered from the next row so it is all-ones in reset
   // and always matches the row the FSM is working on afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1       <= '1;
         sync2       <= '1;
         raw         <= '0;
         key_state   <= '0;
         row_outputs <= '1;
         for (int i = 0; i < KEYS; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         sync1       <= col_inputs;
         sync2       <= sync1;
         row_outputs <= ~(ROWS'(1) << row_nx);
         if (state == SAMPLE) begin
            raw <= ~sync2;
         end
         if (cnt_we) begin
            cnt[key_idx] <= cnt_nx;
         end
         if (push) begin
            key_state[key_idx] <= sample_bit;
         end
      end
   end

   // ---------------------------------------------------------------- event FIFO
   keypad_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (evt_ready),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign evt_valid   = !fifo_empty;
   assign evt_index   = fifo_head.index[IDX_W-1:0];
   assign evt_pressed = fifo_head.pressed;
   assign any_pressed = |key_state;

   // Occupancy and upper index bits are not needed at this level.
   assign unused_fifo = ^{fifo_count, fifo_head.index};

endmodule
`default_nettype wire
